// File: rtl/motor_step_gen_mc.sv
// motor_step_gen_mc: multi-channel step/dir pulse generator with a 1-deep pending-step buffer and position tracking
module motor_step_gen_mc #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     pre_n,
  input  logic [CNT_W-1:0]     pulse_n,
  input  logic [CNT_W-1:0]     post_n,
  input  logic [NCH-1:0]       step_stb,
  input  logic [NCH-1:0]       step_dir,
  input  logic [NCH-1:0]       set_x,
  input  logic [POS_W-1:0]     x_val,
  input  logic                 hold,
  output logic [NCH-1:0]       step,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       missed,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       pending,
  output logic [NCH*POS_W-1:0] x,
  output logic [NCH*POS_W-1:0] x_hold
);
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0] pend_dir, idle, eop, acc, acc_dir, store;
  always_comb begin
    idle = '0;
    eop = '0;
    acc = '0;
    acc_dir = '0;
    store = '0;
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      idle[i] = cnt[i] == '0;
      busy[i] = !idle[i];
      eop[i] = !idle[i] && cnt[i] >= post_n;
      // a strobe landing on end-of-pulse with an empty buffer is issued straight away
      acc[i] = idle[i] ? step_stb[i] : eop[i] && (pending[i] || step_stb[i]);
      acc_dir[i] = (idle[i] || !pending[i]) ? step_dir[i] : pend_dir[i];
      store[i] = !idle[i] && step_stb[i] && (pending[i] ? eop[i] : !eop[i]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      step <= '0;
      dir <= '0;
      missed <= '0;
      pending <= '0;
      pend_dir <= '0;
      x <= '0;
      x_hold <= '0;
    end else begin
      if (hold) x_hold <= x;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= acc[i] ? CNT_W'(1) : (idle[i] || eop[i]) ? '0 : cnt[i] + CNT_W'(1);
        step[i] <= !idle[i] && !eop[i] && cnt[i] >= pre_n && cnt[i] < pulse_n;
        missed[i] <= !idle[i] && !eop[i] && step_stb[i] && pending[i];
        pending[i] <= idle[i] ? pending[i] : step_stb[i] ? (pending[i] || !eop[i]) : (pending[i] && !eop[i]);
        if (store[i]) pend_dir[i] <= step_dir[i];
        if (acc[i]) dir[i] <= acc_dir[i];
        x[i*POS_W +: POS_W] <= set_x[i] ? x_val :
                               acc[i] ? x[i*POS_W +: POS_W] + (acc_dir[i] ? {POS_W{1'b1}} : POS_W'(1)) :
                               x[i*POS_W +: POS_W];
      end
    end
  end
endmodule

// File: tb/tb_motor_step_gen_mc.sv
// tb_motor_step_gen_mc: timestamp-based reference model checked every cycle, plus directed literal checks
module tb_motor_step_gen_mc;
  logic clk = 0, reset = 1, hold = 0;
  logic [15:0] pre_n = 2, pulse_n = 5, post_n = 8;
  logic [3:0] step_stb = 0, step_dir = 0, set_x = 0;
  logic [31:0] x_val = 0;
  logic [3:0] step, dir, missed, busy, pending;
  logic [127:0] x, x_hold;
  int tests = 0, fails = 0;

  motor_step_gen_mc dut (.clk(clk), .reset(reset), .pre_n(pre_n), .pulse_n(pulse_n), .post_n(post_n),
    .step_stb(step_stb), .step_dir(step_dir), .set_x(set_x), .x_val(x_val), .hold(hold),
    .step(step), .dir(dir), .missed(missed), .busy(busy), .pending(pending), .x(x), .x_hold(x_hold));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Model: each channel remembers the cycle of its last accepted step; timing follows from elapsed cycles.
  int cyc;
  int t_acc [4];
  bit pq_v [4], pq_d [4];
  logic [3:0] m_step, m_dir, m_missed;
  logic [31:0] m_x [4], m_xh [4];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      m_step = 0; m_dir = 0; m_missed = 0;
      for (int i = 0; i < 4; i++) begin
        t_acc[i] = -1; pq_v[i] = 0; pq_d[i] = 0; m_x[i] = 0; m_xh[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 4; i++) begin
        int e;
        bit a, d;
        e = cyc - t_acc[i];
        a = 0; d = 0;
        m_missed[i] = 0;
        if (hold) m_xh[i] = m_x[i];
        if (t_acc[i] < 0) begin
          m_step[i] = 0;
          if (step_stb[i]) begin a = 1; d = step_dir[i]; end
        end else if (e >= int'(post_n)) begin
          m_step[i] = 0;
          if (pq_v[i]) begin
            a = 1; d = pq_d[i];
            pq_v[i] = step_stb[i]; pq_d[i] = step_dir[i];
          end else if (step_stb[i]) begin
            a = 1; d = step_dir[i];
          end else t_acc[i] = -1;
        end else begin
          m_step[i] = e >= int'(pre_n) && e < int'(pulse_n);
          if (step_stb[i]) begin
            if (pq_v[i]) m_missed[i] = 1;
            else begin pq_v[i] = 1; pq_d[i] = step_dir[i]; end
          end
        end
        if (a) begin t_acc[i] = cyc; m_dir[i] = d; end
        m_x[i] = set_x[i] ? x_val : a ? m_x[i] + (d ? 32'hFFFF_FFFF : 32'd1) : m_x[i];
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] mb, mp;
    for (int i = 0; i < 4; i++) begin mb[i] = t_acc[i] >= 0; mp[i] = pq_v[i]; end
    chk("step", 128'(step), 128'(m_step));
    chk("dir", 128'(dir), 128'(m_dir));
    chk("missed", 128'(missed), 128'(m_missed));
    chk("busy", 128'(busy), 128'(mb));
    chk("pending", 128'(pending), 128'(mp));
    chk("x", x, {m_x[3], m_x[2], m_x[1], m_x[0]});
    chk("x_hold", x_hold, {m_xh[3], m_xh[2], m_xh[1], m_xh[0]});
  end

  int rises [4], hi [4], mc [4];
  logic [3:0] prev = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (step[i] && !prev[i]) rises[i]++;
      if (step[i]) hi[i]++;
      if (missed[i]) mc[i]++;
    end
    prev = step;
  end

  task automatic drive(input logic [3:0] s, input logic [3:0] d, input logic [3:0] sx,
                       input logic [31:0] xv, input logic h);
    step_stb = s; step_dir = d; set_x = sx; x_val = xv; hold = h;
    @(negedge clk);
    step_stb = 0; step_dir = 0; set_x = 0; hold = 0;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 4; i++) begin rises[i] = 0; hi[i] = 0; mc[i] = 0; end
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_x", x, 0);
    chk("rst_busy", 128'(busy), 0);
    // single pulse on ch0
    drive(4'b0001, 0, 0, 0, 0);
    chk("t1_busy", 128'(busy[0]), 1);
    chk("t1_x0", 128'(x[31:0]), 1);
    repeat (2) @(negedge clk);
    chk("t1_step_hi", 128'(step[0]), 1);
    repeat (3) @(negedge clk);
    chk("t1_step_lo", 128'(step[0]), 0);
    chk("t1_busy_mid", 128'(busy[0]), 1);
    repeat (3) @(negedge clk);
    chk("t1_busy_end", 128'(busy[0]), 0);
    chk("t1_width", 128'(hi[0]), 3);
    chk("t1_rises", 128'(rises[0]), 1);
    // back-to-back via pending on ch1
    drive(4'b0010, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(4'b0010, 0, 0, 0, 0);
    chk("t2_pending", 128'(pending[1]), 1);
    repeat (5) @(negedge clk);
    chk("t2_reaccept_busy", 128'(busy[1]), 1);
    chk("t2_pending_pop", 128'(pending[1]), 0);
    chk("t2_x1", 128'(x[63:32]), 2);
    repeat (2) @(negedge clk);
    chk("t2_second_rise", 128'(step[1]), 1);
    repeat (10) @(negedge clk);
    chk("t2_rises", 128'(rises[1]), 2);
    chk("t2_missed", 128'(mc[1]), 0);
    // overflow on ch2
    drive(4'b0100, 0, 0, 0, 0);
    @(negedge clk);
    drive(4'b0100, 0, 0, 0, 0);
    @(negedge clk);
    drive(4'b0100, 0, 0, 0, 0);
    chk("t3_missed_hi", 128'(missed[2]), 1);
    @(negedge clk);
    chk("t3_missed_lo", 128'(missed[2]), 0);
    repeat (20) @(negedge clk);
    chk("t3_rises", 128'(rises[2]), 2);
    chk("t3_missed_cnt", 128'(mc[2]), 1);
    chk("t3_x2", 128'(x[95:64]), 2);
    // wrap and set_x override on ch0
    drive(0, 0, 4'b0001, 0, 0);
    chk("t4_load0", 128'(x[31:0]), 0);
    drive(4'b0001, 4'b0001, 0, 0, 0);
    chk("t4_wrap", 128'(x[31:0]), 128'(32'hFFFF_FFFF));
    chk("t4_dir", 128'(dir[0]), 1);
    repeat (10) @(negedge clk);
    r = rises[0];
    drive(4'b0001, 0, 4'b0001, 100, 0);
    chk("t4_setx", 128'(x[31:0]), 100);
    repeat (10) @(negedge clk);
    chk("t4_pulse", 128'(rises[0] - r), 1);
    // hold alongside a step on ch3
    drive(0, 0, 4'b1000, 7, 0);
    drive(4'b1000, 0, 0, 0, 1);
    chk("t5_x3", 128'(x[127:96]), 8);
    chk("t5_xh3", 128'(x_hold[127:96]), 7);
    chk("t5_xh0", 128'(x_hold[31:0]), 100);
    repeat (10) @(negedge clk);
    // async reset mid-pulse with pending occupied
    drive(4'hF, 0, 0, 0, 0);
    drive(4'hF, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_pre_step", 128'(step), 128'(4'hF));
    #2 reset = 1;
    #1;
    chk("t6_step", 128'(step), 0);
    chk("t6_busy", 128'(busy), 0);
    chk("t6_pending", 128'(pending), 0);
    chk("t6_x", x, 0);
    chk("t6_xh", x_hold, 0);
    @(negedge clk);
    reset = 0;
    r = rises[0];
    drive(4'b0001, 0, 0, 0, 0);
    chk("t6_busy_after", 128'(busy[0]), 1);
    chk("t6_x_after", 128'(x[31:0]), 1);
    repeat (10) @(negedge clk);
    chk("t6_pulse_after", 128'(rises[0] - r), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
